// File: rtl/x_metric_selector_pkg.sv
// Shared constants for the X-metric selector slice.
// State encoding, metric width and index-width helper.
package x_metric_selector_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_SUM  = 3'd3;
  localparam logic [2:0] S_CMP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int N_DEF    = 16;
  localparam int METRIC_W = 2 * N_DEF;

  // clog2 with a floor of 1 bit
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/x_metric_selector_mag.sv
// Complex magnitude-squared: registered squares, then registered sum.
// Reusable by any metric block that needs |z|^2.
module cplx_mag_sq
  import x_metric_selector_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [N-1:0]   trace_r,
  input  logic [N-1:0]   trace_i,
  output logic [2*N-1:0] mag
);

  localparam int W = 2 * N;

  logic signed [W-1:0] sq_r;
  logic signed [W-1:0] sq_i;
  logic signed [W-1:0] ext_r;
  logic signed [W-1:0] ext_i;

  assign ext_r = W'($signed(trace_r));
  assign ext_i = W'($signed(trace_i));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq_r <= '0;
      sq_i <= '0;
    end else if (load) begin
      sq_r <= ext_r * ext_r;
      sq_i <= ext_i * ext_i;
    end
  end

  // Each square is at most 2^(2N-2), so the unsigned sum cannot wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mag <= '0;
    else      mag <= $unsigned(sq_r) + $unsigned(sq_i);
  end

endmodule

// File: rtl/x_metric_selector.sv
// X-metric selector: sequences trace calculations per candidate
// and keeps the index of the largest |trace|^2.
module x_metric_selector
  import x_metric_selector_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int NUM_CAND = 16,
  parameter int IDX_W    = idx_w(NUM_CAND)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             calc_start,
  output logic [IDX_W-1:0] cand_idx,
  input  logic             trace_valid,
  input  logic [N-1:0]     trace_r,
  input  logic [N-1:0]     trace_i,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] best_idx,
  output logic [2*N-1:0]   best_metric
);

  localparam int MW = 2 * N;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CAND - 1);

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic          first;
  logic          load;
  logic [MW-1:0] metric;

  assign load = (state == S_WAIT) && trace_valid && !abort;

  cplx_mag_sq #(.N(N)) u_mag (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .trace_r (trace_r),
    .trace_i (trace_i),
    .mag     (metric)
  );

  assign calc_start = (state == S_REQ);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_REQ;
      S_REQ:   state_nx = S_WAIT;
      S_WAIT:  if (trace_valid) state_nx = S_SUM;
      S_SUM:   state_nx = S_CMP;
      S_CMP:   state_nx = (cand_idx == LAST) ? S_DONE : S_REQ;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort && state != S_IDLE) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Strict compare: a tie never displaces the earlier candidate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand_idx    <= '0;
      first       <= 1'b0;
      best_idx    <= '0;
      best_metric <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        cand_idx <= '0;
        first    <= 1'b0;
      end
      if (state == S_CMP && !abort) begin
        if (!first || metric > best_metric) begin
          best_metric <= metric;
          best_idx    <= cand_idx;
        end
        first <= 1'b1;
        if (cand_idx != LAST) cand_idx <= cand_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_x_metric_selector.sv
// Directed bench for x_metric_selector (4- and 2-candidate builds).
// Inputs change on negedge; outputs are sampled on negedge.
module tb_x_metric_selector;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               start4, abort4, tv4;
  logic signed [15:0] tr4, ti4;
  logic               cs4, busy4, done4;
  logic [1:0]         idx4, bidx4;
  logic [31:0]        bm4;

  logic               start2, abort2, tv2;
  logic signed [15:0] tr2, ti2;
  logic               cs2, busy2, done2;
  logic [0:0]         idx2, bidx2;
  logic [31:0]        bm2;

  x_metric_selector #(.N(16), .NUM_CAND(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4),
    .calc_start(cs4), .cand_idx(idx4), .trace_valid(tv4),
    .trace_r(tr4), .trace_i(ti4), .busy(busy4), .done(done4),
    .best_idx(bidx4), .best_metric(bm4)
  );

  x_metric_selector #(.N(16), .NUM_CAND(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .calc_start(cs2), .cand_idx(idx2), .trace_valid(tv2),
    .trace_r(tr2), .trace_i(ti2), .busy(busy2), .done(done2),
    .best_idx(bidx2), .best_metric(bm2)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cs_cnt4 = 0;

  always @(negedge clk) if (rst && cs4) cs_cnt4++;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  task automatic wait_cs4(output int tmo);
    int w;
    w = 0;
    tmo = 0;
    while (!cs4 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cs4) tmo = 1;
  endtask

  task automatic serve4(input logic signed [15:0] r, input logic signed [15:0] i);
    @(negedge clk);
    tv4 = 1'b1; tr4 = r; ti4 = i;
    @(negedge clk);
    tv4 = 1'b0; tr4 = '0; ti4 = '0;
  endtask

  task automatic drive4(
    input  logic signed [15:0] tr[4],
    input  logic signed [15:0] ti[4],
    output int lat[4],
    output int idxs[4],
    output int dw,
    output int tmo
  );
    int t;
    tmo = 0;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_cs4(t);
      tmo += t;
      idxs[k] = int'(idx4);
      serve4(tr[k], ti[k]);
      lat[k] = 1;
      while (!(cs4 || done4) && lat[k] < 20) begin
        @(negedge clk);
        lat[k]++;
      end
    end
    dw = 0;
    while (done4 && dw < 5) begin
      dw++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    start4 = 0; abort4 = 0; tv4 = 0; tr4 = 0; ti4 = 0;
    start2 = 0; abort2 = 0; tv2 = 0; tr2 = 0; ti2 = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy4, done4, cs4} !== 3'b000) begin
      n_mis++; $display("FAIL reset_ctl4: got %b want 000", {busy4, done4, cs4});
    end
    n_cmp++; if ({idx4, bidx4} !== 4'b0) begin
      n_mis++; $display("FAIL reset_idx4: got %h want 0", {idx4, bidx4});
    end
    n_cmp++; if (bm4 !== 32'd0) begin
      n_mis++; $display("FAIL reset_metric4: got %h want 0", bm4);
    end
    n_cmp++; if ({busy2, done2, cs2, bm2} !== 35'd0) begin
      n_mis++; $display("FAIL reset_dut2: got %h want 0", {busy2, done2, cs2, bm2});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic4;
    int lat[4], idxs[4], dw, tmo, cs0;
    #1 cs0 = cs_cnt4;
    drive4('{16'sd3, 16'sd0, -16'sd5, 16'sd1},
           '{16'sd4, 16'sd0, 16'sd0, 16'sd1}, lat, idxs, dw, tmo);
    n_cmp++; if (tmo !== 0) begin
      n_mis++; $display("FAIL basic_timeout: got %0d want 0", tmo);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (lat[k] !== 3) begin
        n_mis++; $display("FAIL basic_lat[%0d]: got %0d want 3", k, lat[k]);
      end
      n_cmp++; if (idxs[k] !== k) begin
        n_mis++; $display("FAIL basic_idx[%0d]: got %0d want %0d", k, idxs[k], k);
      end
    end
    n_cmp++; if (dw !== 1) begin
      n_mis++; $display("FAIL basic_done_w: got %0d want 1", dw);
    end
    #1;
    n_cmp++; if (cs_cnt4 - cs0 !== 4) begin
      n_mis++; $display("FAIL basic_cs_cnt: got %0d want 4", cs_cnt4 - cs0);
    end
    n_cmp++; if (bidx4 !== 2'd0) begin
      n_mis++; $display("FAIL basic_best_idx: got %0d want 0", bidx4);
    end
    n_cmp++; if (bm4 !== 32'd25) begin
      n_mis++; $display("FAIL basic_best_metric: got %0d want 25", bm4);
    end
  endtask

  task automatic test_sign2;
    int w;
    logic signed [15:0] r[2];
    logic signed [15:0] i[2];
    r = '{16'sd1, 16'sh8000};
    i = '{16'sd0, 16'sh8000};
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      w = 0;
      while (!cs2 && w < 20) begin @(negedge clk); w++; end
      @(negedge clk);
      tv2 = 1'b1; tr2 = r[k]; ti2 = i[k];
      @(negedge clk);
      tv2 = 1'b0; tr2 = '0; ti2 = '0;
    end
    w = 0;
    while (!done2 && w < 20) begin @(negedge clk); w++; end
    n_cmp++; if (done2 !== 1'b1) begin
      n_mis++; $display("FAIL sign2_done: got %b want 1", done2);
    end
    n_cmp++; if (bidx2 !== 1'b1) begin
      n_mis++; $display("FAIL sign2_best_idx: got %0d want 1", bidx2);
    end
    n_cmp++; if (bm2 !== 32'h8000_0000) begin
      n_mis++; $display("FAIL sign2_best_metric: got %h want 80000000", bm2);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore;
    int cs0, tmo;
    #1 cs0 = cs_cnt4;
    @(negedge clk); tv4 = 1'b1; tr4 = 16'sd100; ti4 = 16'sd100;
    @(negedge clk); tv4 = 1'b0; tr4 = '0; ti4 = '0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if ({busy4, cs_cnt4 - cs0} !== {1'b0, 32'd0}) begin
      n_mis++; $display("FAIL idle_tv_ctl: got busy=%b cs=%0d want 0/0", busy4, cs_cnt4 - cs0);
    end
    n_cmp++; if ({bidx4, bm4} !== {2'd0, 32'd25}) begin
      n_mis++; $display("FAIL idle_tv_best: got %0d/%0d want 0/25", bidx4, bm4);
    end
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    wait_cs4(tmo);
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    #1;
    n_cmp++; if ({busy4, cs4, idx4} !== {1'b1, 1'b0, 2'd0}) begin
      n_mis++; $display("FAIL busy_start: got %b%b%0d want 1 0 0", busy4, cs4, idx4);
    end
    n_cmp++; if (cs_cnt4 - cs0 !== 1) begin
      n_mis++; $display("FAIL busy_start_cs: got %0d want 1", cs_cnt4 - cs0);
    end
    abort4 = 1'b1;
    @(negedge clk); abort4 = 1'b0;
    n_cmp++; if (busy4 !== 1'b0) begin
      n_mis++; $display("FAIL busy_start_abort: got %b want 0", busy4);
    end
  endtask

  task automatic test_abort;
    int lat[4], idxs[4], dw, tmo, dcnt;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_cs4(tmo);
      serve4(16'sd2, 16'sd2);
    end
    wait_cs4(tmo);
    @(negedge clk);
    abort4 = 1'b1;
    @(negedge clk); abort4 = 1'b0;
    n_cmp++; if (busy4 !== 1'b0) begin
      n_mis++; $display("FAIL abort_busy: got %b want 0", busy4);
    end
    dcnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (done4 || cs4) dcnt++;
      @(negedge clk);
    end
    n_cmp++; if (dcnt !== 0) begin
      n_mis++; $display("FAIL abort_no_done: got %0d want 0", dcnt);
    end
    drive4('{16'sd0, 16'sd2, 16'sd0, 16'sd1},
           '{16'sd1, 16'sd0, -16'sd3, 16'sd1}, lat, idxs, dw, tmo);
    n_cmp++; if ({bidx4, bm4} !== {2'd2, 32'd9}) begin
      n_mis++; $display("FAIL abort_restart: got %0d/%0d want 2/9", bidx4, bm4);
    end
    n_cmp++; if (dw !== 1 || lat[3] !== 3) begin
      n_mis++; $display("FAIL abort_restart_tim: got dw=%0d lat=%0d want 1/3", dw, lat[3]);
    end
  endtask

  task automatic test_async_reset;
    int lat[4], idxs[4], dw, tmo;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    wait_cs4(tmo);
    serve4(16'sd7, 16'sd7);
    wait_cs4(tmo);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({busy4, cs4, done4, idx4} !== 5'b0) begin
      n_mis++; $display("FAIL areset_ctl: got %b want 00000", {busy4, cs4, done4, idx4});
    end
    n_cmp++; if ({bidx4, bm4} !== 34'd0) begin
      n_mis++; $display("FAIL areset_best: got %0d/%0d want 0/0", bidx4, bm4);
    end
    @(negedge clk); rst = 1'b1;
    drive4('{16'sd3, 16'sd0, -16'sd5, 16'sd1},
           '{16'sd4, 16'sd0, 16'sd0, 16'sd1}, lat, idxs, dw, tmo);
    n_cmp++; if ({bidx4, bm4} !== {2'd0, 32'd25} || dw !== 1) begin
      n_mis++; $display("FAIL areset_rerun: got %0d/%0d dw=%0d want 0/25 dw=1", bidx4, bm4, dw);
    end
  endtask

  initial begin
    test_reset();
    test_basic4();
    test_sign2();
    test_ignore();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
